div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU.
- The execute stage is the initiator: it raises start, holds operands and stalls the pipeline.
- This block is the responder: it iterates one quotient bit per cycle, then returns a 64-bit {remainder, quotient} with a ready flag.
- Execute stage forwards the result to HI (remainder) and LO (quotient).

Parameters:
- DATA_W, 32, operand width; the counter and internal widths derive from it (64-bit result, 65-bit shift register).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low: asserted when rst==`Rst_Enable (1'b0) at a rising edge of clk
- signed_div_i  input  1  1 = signed DIV, 0 = DIVU
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request from execute stage; held high until ready_o is seen
- annul_i  input  1  abort the current or requested operation (flush)
- result_o  output  64  {remainder[31:0], quotient[31:0]}; valid only while ready_o=1
- ready_o  output  1  result valid

Behaviour:
- Reset: state=FREE, cnt=0, ready_o=0, result_o=0, internal registers=0. Reset mid-operation discards all progress.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE:
  - start_i=1 and annul_i=0: if opdata2_i==0, go to BYZERO.
  - Otherwise capture the operands, go to ON, cnt=0.
  - Signed mode: capture |opdata1_i| and |opdata2_i| as two's complement magnitudes, and latch both sign bits.
  - Unsigned mode: capture raw values.
  - Shift register init = {32'b0, dividend_mag, 1'b0}.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge go to END with result_o=0 and ready_o=1.
- ON: each edge:
  - If annul_i=1, go to FREE, ready_o=0; no result is produced.
  - Otherwise, while cnt<32: diff = sr[63:32] - divisor (33-bit).
    - diff negative: sr = {sr[63:0], 1'b0}.
    - Else: sr = {diff[31:0], sr[31:0], 1'b1}.
    - cnt++.
  - When cnt==32, finalize:
    - quotient = sr[31:0]; negate it if signed and the sign bits differ.
    - remainder = sr[64:33]; negate it if signed and the dividend was negative.
    - Load result_o, set ready_o=1, go to END.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0, go to FREE with ready_o=0 and result_o=0.
- Latency, counting the edge that samples start_i as edge 0:
  - Iterations on edges 1..32.
  - ready_o visible after edge 33.
  - Divide-by-zero: ready_o after edge 1.
- Operands are captured only at the start edge; later input changes are ignored.
- Overflow case 0x80000000 / -1 (signed) wraps: quotient=0x80000000, remainder=0; no trap.
- Simultaneous start_i and annul_i in FREE: stay in FREE.
- annul_i in END: ignored; END exits only via start_i=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Add to shared define.v:
  - DivFree, DivByZero, DivOn, DivEnd (2'b00..2'b11).
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - Existing `Rst_Enable redefined 1'b0 for this block's polarity.
- No sub-module: the single conditional-subtract step is inline, one always block for state/datapath plus a small combinational diff.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises after edge 33; result_o = {32'd2, 32'd14}; drop start -> ready_o=0 and result_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}; signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
- Divisor 0 (either mode) -> ready_o=1 after edge 1, result_o=0; remains until start_i=0.
- Start 1000/3, assert annul_i at edge 10 -> FREE on next edge, ready_o never rises; then start 9/3 -> {0, 3} after edge 33.
- Start 1000/3, rst=0 at edge 20 -> ready_o=0, result_o=0, state FREE; back-to-back operations after release each take 34 edges.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and control constants for the multi-cycle divider
package div_pkg;
  localparam int DIV_W = 32;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
endpackage

// File: rtl/div.sv
// div: restoring divider, one quotient bit per cycle, returns {remainder, quotient}
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [2*DATA_W:0] sr;
  logic [DATA_W-1:0] divisor, dmag, vmag, quo, rem;
  logic [DATA_W:0] diff;
  logic s1, s2;
  always_comb begin
    dmag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    vmag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    diff = {1'b0, sr[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
    quo  = (s1 ^ s2) ? -sr[DATA_W-1:0] : sr[DATA_W-1:0];
    rem  = s1 ? -sr[2*DATA_W:DATA_W+1] : sr[2*DATA_W:DATA_W+1];
  end
  // sign bits are latched as zero in unsigned mode so finalize needs no mode check
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      sr       <= '0;
      divisor  <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      ready_o  <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= '0;
              sr      <= {{DATA_W{1'b0}}, dmag, 1'b0};
              divisor <= vmag;
              s1      <= signed_div_i & opdata1_i[DATA_W-1];
              s2      <= signed_div_i & opdata2_i[DATA_W-1];
            end
          end
        end
        DIV_BYZERO: begin
          state    <= DIV_END;
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            state   <= DIV_FREE;
            ready_o <= DIV_RESULT_NOT_READY;
          end else if (cnt != CNT_W'(DATA_W)) begin
            sr  <= diff[DATA_W] ? {sr[2*DATA_W-1:0], 1'b0} : {diff[DATA_W-1:0], sr[DATA_W-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {rem, quo};
            ready_o  <= DIV_RESULT_READY;
            state    <= DIV_END;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: directed checks of div latency, signed/unsigned results, divide-by-zero, annul and reset
module tb_div;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  int compared = 0;
  int mismatched = 0;
  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // starts an operation, scrambles operands after capture, ends in END with start held
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    @(negedge clk);
    opdata1_i = ~a;
    opdata2_i = 32'h5;
    signed_div_i = ~sgn;
    repeat (32) @(negedge clk);
    chk({tag, "_not_ready_e32"}, {63'b0, ready_o}, 64'd0);
    @(negedge clk);
    chk({tag, "_ready_e33"}, {63'b0, ready_o}, 64'd1);
    chk({tag, "_result"}, result_o, exp);
  endtask
  task automatic finish_op(input string tag);
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_ready"}, {63'b0, ready_o}, 64'd0);
    chk({tag, "_drop_result"}, result_o, 64'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_ready", {63'b0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    run_op("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    annul_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("end_hold_ready", {63'b0, ready_o}, 64'd1);
    chk("end_hold_result", result_o, {32'd2, 32'd14});
    annul_i = 1'b0;
    finish_op("u100_7");
    run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    finish_op("s_m7_2");
    run_op("s_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
    finish_op("s_7_m2");
    run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF});
    finish_op("u_max_1");
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    finish_op("s_ovf");
    for (int m = 0; m < 2; m++) begin
      signed_div_i = m[0];
      opdata1_i = 32'd55;
      opdata2_i = 32'd0;
      start_i = 1'b1;
      @(negedge clk);
      chk("byzero_e0", {63'b0, ready_o}, 64'd0);
      @(negedge clk);
      chk("byzero_ready", {63'b0, ready_o}, 64'd1);
      chk("byzero_result", result_o, 64'd0);
      repeat (3) @(negedge clk);
      chk("byzero_hold", {63'b0, ready_o}, 64'd1);
      finish_op("byzero");
    end
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("annul_no_ready", {63'b0, ready_o}, 64'd0);
      @(negedge clk);
    end
    run_op("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    finish_op("u9_3");
    opdata1_i = 32'd20;
    opdata2_i = 32'd4;
    start_i = 1'b1;
    annul_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("start_annul_free", {63'b0, ready_o}, 64'd0);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'b0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_ready", {63'b0, ready_o}, 64'd0);
    run_op("u1000_3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
    finish_op("u1000_3");
    run_op("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2});
    finish_op("s_m100_7");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
